// File: rtl/genius_button_debouncer_if.sv
// genius_button_debouncer_if
// Bundles the raw button inputs and the conditioned outputs of the debouncer.
//   btn_raw      raw, bouncing, active-high button levels (asynchronous)
//   btn_level    debounced button levels
//   press_valid  one-cycle pulse for an accepted single press
//   press_id     index of the accepted button (0 when press_valid is low)
//   multi_press  one-cycle pulse for a rejected simultaneous or overlapping press
// master: drives btn_raw and consumes the results. slave: the debouncer.
interface genius_button_debouncer_if #(
    parameter int NUM_BUTTONS = 4
);
    localparam int ID_W = $clog2(NUM_BUTTONS);

    logic [NUM_BUTTONS-1:0] btn_raw;
    logic [NUM_BUTTONS-1:0] btn_level;
    logic                   press_valid;
    logic [ID_W-1:0]        press_id;
    logic                   multi_press;

    modport master (
        output btn_raw,
        input  btn_level, press_valid, press_id, multi_press
    );

    modport slave (
        input  btn_raw,
        output btn_level, press_valid, press_id, multi_press
    );
endinterface

// File: rtl/genius_button_debouncer.sv
// genius_button_debouncer
// Synchronises and debounces NUM_BUTTONS push buttons and turns a clean single
// press into a one-cycle press event with the button index. Presses that
// start together, or while another button is already down, are flagged on
// multi_press instead.
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    genius_button_debouncer_if.slave (btn_raw in; btn_level,
//          press_valid, press_id, multi_press out, all registered)

// One button: two-flop synchroniser followed by a stability counter. The
// debounced level only moves after DEBOUNCE_CYCLES consecutive edges on which
// the synchronised input disagreed with it.
module genius_button_debouncer_lane #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             s1;
    logic             s2;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            cnt   <= '0;
            level <= 1'b0;
        end else begin
            s1 <= raw;
            s2 <= s1;
            if (s2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level <= s2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

module genius_button_debouncer #(
    parameter int NUM_BUTTONS     = 4,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    genius_button_debouncer_if.slave  bus
);
    localparam int ID_W = $clog2(NUM_BUTTONS);

    logic [NUM_BUTTONS-1:0] level;
    logic [NUM_BUTTONS-1:0] prev_level;
    logic [NUM_BUTTONS-1:0] rise;
    logic [ID_W-1:0]        rise_id;
    logic                   rise_one_hot;
    logic                   others_high;
    logic                   accept;
    logic                   press_valid_q;
    logic                   multi_press_q;
    logic [ID_W-1:0]        press_id_q;

    for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_lane
        genius_button_debouncer_lane #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_lane (
            .clk   (clk),
            .rst_n (rst_n),
            .raw   (bus.btn_raw[i]),
            .level (level[i])
        );
    end

    // Rising debounced edges since the previous cycle. A press is only clean
    // when it is the sole rise and nothing else is being held down.
    assign rise = level & ~prev_level;

    always_comb begin
        rise_id = '0;
        for (int i = 0; i < NUM_BUTTONS; i++) begin
            if (rise[i]) rise_id = ID_W'(i);
        end
        rise_one_hot = (rise != '0) && ((rise & (rise - 1'b1)) == '0);
        others_high  = (level & ~rise) != '0;
        accept       = rise_one_hot && !others_high;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_level    <= '0;
            press_valid_q <= 1'b0;
            multi_press_q <= 1'b0;
            press_id_q    <= '0;
        end else begin
            prev_level    <= level;
            press_valid_q <= accept;
            multi_press_q <= (rise != '0) && !accept;
            press_id_q    <= accept ? rise_id : '0;
        end
    end

    assign bus.btn_level   = level;
    assign bus.press_valid = press_valid_q;
    assign bus.multi_press = multi_press_q;
    assign bus.press_id    = press_id_q;
endmodule

// File: doc/genius_button_debouncer.md
# genius_button_debouncer

Input conditioner for the Genius game's colour buttons, sitting directly upstream of the press counter and game controller. It synchronises NUM_BUTTONS raw, bouncing push-button inputs, debounces each independently with a per-button stability counter, and emits a single-cycle, one-hot-free press event: `press_valid` plus the encoded button index. That pulse drives the counter's `enable` and the controller's colour-compare logic. Simultaneous or overlapping presses are rejected and flagged.

## Interface
- `NUM_BUTTONS`, 4: number of button inputs; ≥2.
- `DEBOUNCE_CYCLES`, 16: consecutive stable cycles required to accept a level change; ≥2. Per-button counter width is $clog2(DEBOUNCE_CYCLES).
- `clk`  input  1  system clock; all state is on the rising edge.
- `rst_n`  input  1  asynchronous, active-low reset; clears all state.
- `btn_raw`  input  NUM_BUTTONS  raw buttons, active high, asynchronous to `clk`.
- `btn_level`  output  NUM_BUTTONS  debounced levels. Reset value 0.
- `press_valid`  output  1  one-cycle pulse for an accepted press. Reset value 0.
- `press_id`  output  $clog2(NUM_BUTTONS)  index of the accepted button. Valid only when `press_valid`=1, 0 otherwise. Reset value 0.
- `multi_press`  output  1  one-cycle pulse when a press is rejected. Reset value 0.

## Operation
- **Synchroniser:** two flops per bit (`s1`, `s2`), reset 0. Only `s2` is used downstream.
- **Debounce, per button i:** compare `s2[i]` with `btn_level[i]`.
  - Equal: counter cleared to 0.
  - Differ and counter < DEBOUNCE_CYCLES-1: counter increments.
  - Differ and counter == DEBOUNCE_CYCLES-1: `btn_level[i]` <= `s2[i]` and counter cleared.
  - Result: a change is accepted after exactly DEBOUNCE_CYCLES consecutive mismatched edges. Any single matching cycle restarts the count.
- **Release:** follows the same rule in the 1→0 direction. It produces no event.
- **Press detection:** compute `rise` = new `btn_level` & ~old `btn_level` each cycle.
  - Accepted: `rise` has exactly one bit set and no other `btn_level` bit is high after the update. Next edge, `press_valid`=1 and `press_id`=index of that bit.
  - Rejected: `rise` has ≥2 bits set, or one bit set while another button's debounced level is already high. Next edge, `multi_press`=1, `press_valid`=0, `press_id`=0.
  - `press_valid` and `multi_press` are never high together.
- **Holding a button** produces exactly one event. Another event requires a debounced release, then a new debounced press.
- **Reset (any time, including mid-debounce):** synchronisers, counters, levels and outputs all go to 0 immediately. A button held through reset release is re-debounced and yields a fresh press.

## Timing
- Edge E0 is the first edge sampling `btn_raw[i]`=1, held stable from then on:
  - `s1` updates at E0; `s2` at E1.
  - Mismatched edges are E2..E(DEBOUNCE_CYCLES+1).
  - `btn_level[i]`=1 after E(DEBOUNCE_CYCLES+1).
  - `press_valid` is high for exactly one cycle after E(DEBOUNCE_CYCLES+2).
- Press latency is DEBOUNCE_CYCLES+3 edges from E0 inclusive. Release latency to `btn_level` is DEBOUNCE_CYCLES+2 edges.
- All outputs are registered; there are no combinational paths from inputs.

## Test plan
- **Reset values:** assert `rst_n`=0 with `btn_raw`=4'b1111 → all outputs 0. Release reset with button 2 held, DEBOUNCE_CYCLES=16 → `press_valid`=1, `press_id`=2 for one cycle, 19 edges after the first sampling edge.
- **Clean press, DEBOUNCE_CYCLES=4:** hold `btn_raw`=4'b0010 → `btn_level`=4'b0010 after E5; `press_valid`=1, `press_id`=1 after E6 only. Hold 100 cycles → no further events.
- **Bounce, DEBOUNCE_CYCLES=4:** toggle `btn_raw[3]` high 3 cycles / low 1 cycle repeatedly → `btn_level` stays 0 and no event. Then hold high → a single press with `press_id`=3.
- **Simultaneous press:** `btn_raw` 0→4'b0101 on the same edge → `multi_press` pulses once, `press_valid` stays 0, and `btn_level`=4'b0101.
- **Overlap:** button 0 accepted and held, then button 3 pressed → `multi_press` pulses. Release both, re-press button 3 alone → `press_valid`=1, `press_id`=3.
- **Reset mid-debounce, DEBOUNCE_CYCLES=16:** pulse `rst_n` low 2 cycles after 10 mismatched edges, button held throughout → counter restarts; press reported 19 edges after reset release.
